// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: a valid/ready request channel
// and an in-order response channel with no back-pressure.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, issues word-aligned
// requests to instruction memory and buffers returned words with their PCs
// in a small prefetch FIFO that feeds decode. Branch redirects flush the
// FIFO and turn every in-flight request into a response that is discarded.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 pc_src,
  input  logic [31:0]          pc_branch,
  output logic [31:0]          instruction,
  output logic [31:0]          pc,
  output logic                 valid
);

  localparam int          CW  = $clog2(FIFO_DEPTH + 1);
  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];

  logic [31:0]   branch_target;
  logic          pop;
  logic          accept;
  logic          rsp_drop;
  logic          rsp_take;
  logic          rsp_legal;
  logic [CW+1:0] credit_used;
  logic [CW:0]   drop_redirect;

  assign branch_target = pc_branch & 32'hFFFF_FFFC;

  assign valid = (count != '0);
  assign pop   = valid && !stall && !pc_src;

  // The entry leaving the FIFO this cycle frees its slot for a new request;
  // without this a 2-deep buffer could not sustain one instruction per cycle.
  assign credit_used = (CW+2)'(outstanding) + (CW+2)'(count) + (CW+2)'(drop)
                     - (CW+2)'(pop);

  assign imem.imem_req_valid = !rst && (credit_used < (CW+2)'(FIFO_DEPTH));
  assign imem.imem_req_addr  = fetch_pc;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;

  // Wrong-path responses are always older than right-path ones, so while
  // drop is non-zero the response at hand belongs to the abandoned path.
  assign rsp_drop  = imem.imem_rsp_valid && (drop != '0);
  assign rsp_take  = imem.imem_rsp_valid && (drop == '0) && (outstanding != '0);
  assign rsp_legal = rsp_drop || rsp_take;

  // On a redirect everything in flight (including a request accepted this
  // cycle) is discarded later; a response arriving now is discarded at once.
  assign drop_redirect = (CW+1)'(drop) + (CW+1)'(outstanding)
                       + (CW+1)'(accept) - (CW+1)'(rsp_legal);

  assign instruction = valid ? fifo_instr[rd_ptr] : NOP;
  assign pc          = valid ? fifo_pc[rd_ptr]    : '0;

  // PC, credit counters and FIFO pointers; redirect outranks stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (pc_src) begin
      fetch_pc    <= branch_target;
      rsp_pc      <= branch_target;
      outstanding <= '0;
      drop        <= drop_redirect[CW-1:0];
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_take) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
      drop        <= drop - CW'(rsp_drop);
      count       <= count + CW'(rsp_take) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !pc_src && rsp_take) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= imem.imem_rsp_data;
    end
  end

  // A response with nothing in flight is a memory protocol error; it is ignored.
  assert property (@(posedge clk) disable iff (rst)
    !(imem.imem_rsp_valid && (outstanding == '0) && (drop == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a short random stretch,
// checked every cycle against a queue-level model of fetch behaviour.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .stall       (stall),
    .pc_src      (pc_src),
    .pc_branch   (pc_branch),
    .instruction (instruction),
    .pc          (pc),
    .valid       (valid)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int lat    = 1;
  logic [31:0] key = '0;

  typedef struct { logic [31:0] addr; logic wrong; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        q_mem[$];
  ent_t        q_buf[$];
  logic [31:0] req_pc = RESET_PC;
  logic        init   = 1'b0;
  int          cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    pc_src = 1'b0;
    bus.imem_req_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Memory model, reference model and per-cycle compare.
  always @(negedge clk) begin
    logic        rv;
    logic [31:0] rd;
    logic        pop_m;
    logic        exp_rv;
    logic        acc;
    int          used;
    req_t        r;
    rv = 1'b0;
    rd = '0;
    if (init && !rst && q_mem.size() > 0 && q_mem[0].due <= cyc) begin
      rv = 1'b1;
      rd = q_mem[0].addr ^ key;
    end
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    #1;
    pop_m  = (q_buf.size() > 0) && !stall && !pc_src;
    used   = q_mem.size() + q_buf.size() - (pop_m ? 1 : 0);
    exp_rv = !rst && (used < DEPTH);
    if (init) begin
      chk("m_valid", valid, q_buf.size() > 0);
      chk("m_pc", pc, (q_buf.size() > 0) ? q_buf[0].pc : 32'h0);
      chk("m_instr", instruction, (q_buf.size() > 0) ? q_buf[0].data : NOP);
      chk("m_req_valid", bus.imem_req_valid, exp_rv);
      chk("m_req_addr", bus.imem_req_addr, req_pc);
    end
    if (rst) begin
      init   = 1'b1;
      req_pc = RESET_PC;
      q_mem.delete();
      q_buf.delete();
    end else if (init) begin
      acc = exp_rv && bus.imem_req_ready;
      if (rv) begin
        r = q_mem.pop_front();
        if (!r.wrong && !pc_src) q_buf.push_back('{r.addr, rd});
      end
      if (pop_m) q_buf.delete(0);
      if (acc) q_mem.push_back('{req_pc, pc_src, cyc + lat});
      if (pc_src) begin
        foreach (q_mem[i]) q_mem[i].wrong = 1'b1;
        q_buf.delete();
        req_pc = pc_branch & 32'hFFFF_FFFC;
      end else if (acc) begin
        req_pc = req_pc + 32'd4;
      end
    end
    cyc++;
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1;
    stall = 1'b0;
    pc_src = 1'b0;
    pc_branch = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;

    // Reset, then zero-wait streaming and a 5-cycle stall.
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_instr", instruction, NOP);
    chk("rst_pc", pc, 0);
    chk("rst_addr", bus.imem_req_addr, RESET_PC);
    chk("rst_req_valid", bus.imem_req_valid, 1);
    step();
    step();
    #1;
    chk("stream_first_valid", valid, 1);
    chk("stream_first_pc", pc, 32'h0);
    chk("stream_first_instr", instruction, 32'h0);
    step();
    step();
    stall = 1'b1;
    #1;
    chk("stall_head_pc", pc, 32'h8);
    repeat (4) step();
    #1;
    chk("stall_full_req", bus.imem_req_valid, 0);
    chk("stall_hold_pc", pc, 32'h8);
    step();
    stall = 1'b0;
    step();
    #1;
    chk("release_pc12", pc, 32'hC);
    step();
    #1;
    chk("release_pc16", pc, 32'h10);
    chk("release_valid", valid, 1);
    repeat (4) step();

    // Request back-pressure at address 0x10.
    do_reset();
    repeat (4) step();
    bus.imem_req_ready = 1'b0;
    #1;
    chk("bp_addr_first", bus.imem_req_addr, 32'h10);
    step();
    step();
    #1;
    chk("bp_addr_held", bus.imem_req_addr, 32'h10);
    chk("bp_req_valid", bus.imem_req_valid, 1);
    step();
    bus.imem_req_ready = 1'b1;
    repeat (8) step();

    // Redirect with two requests in flight, memory latency 3.
    lat = 3;
    key = 32'hA5A5_0000;
    do_reset();
    repeat (2) step();
    pc_src = 1'b1;
    pc_branch = 32'h0000_0100;
    #1;
    chk("redir_req_blocked", bus.imem_req_valid, 0);
    step();
    pc_src = 1'b0;
    #1;
    chk("redir_flushed", valid, 0);
    repeat (5) step();
    #1;
    chk("redir_first_valid", valid, 1);
    chk("redir_first_pc", pc, 32'h100);
    chk("redir_first_instr", instruction, 32'hA5A5_0100);
    step();
    #1;
    chk("redir_second_pc", pc, 32'h104);
    repeat (6) step();

    // Misaligned redirect while stalled with a full FIFO.
    lat = 1;
    key = 32'h0F0F_0000;
    do_reset();
    stall = 1'b1;
    repeat (3) step();
    pc_src = 1'b1;
    pc_branch = 32'h0000_0203;
    #1;
    chk("full_req_valid", bus.imem_req_valid, 0);
    chk("full_head_pc", pc, 32'h0);
    step();
    pc_src = 1'b0;
    #1;
    chk("mis_valid", valid, 0);
    chk("mis_addr", bus.imem_req_addr, 32'h200);
    step();
    #1;
    chk("mis_wait", valid, 0);
    step();
    #1;
    chk("mis_pc", pc, 32'h200);
    chk("mis_instr", instruction, 32'h0F0F_0200);
    stall = 1'b0;
    repeat (4) step();

    // Random stall, back-pressure, latency and redirects.
    for (int i = 0; i < 80; i++) begin
      step();
      stall = ($urandom_range(0, 3) == 0);
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      pc_src = !pc_src && ($urandom_range(0, 11) == 0);
      pc_branch = $urandom & 32'h0000_0FFF;
    end
    step();
    pc_src = 1'b0;
    stall = 1'b0;
    bus.imem_req_ready = 1'b1;
    lat = 3;
    repeat (4) step();

    // Reset in the middle of operation.
    stall = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midrst_req_forced", bus.imem_req_valid, 0);
    step();
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_req_valid", bus.imem_req_valid, 0);
    chk("midrst_instr", instruction, NOP);
    chk("midrst_pc", pc, 32'h0);
    rst = 1'b0;
    stall = 1'b0;
    #1;
    chk("midrst_restart_addr", bus.imem_req_addr, RESET_PC);
    chk("midrst_restart_req", bus.imem_req_valid, 1);
    repeat (8) step();

    // PC wrap after a redirect near the top of the address space.
    lat = 1;
    key = '0;
    do_reset();
    repeat (3) step();
    pc_src = 1'b1;
    pc_branch = 32'hFFFF_FFFE;
    step();
    pc_src = 1'b0;
    #1;
    chk("wrap_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    step();
    #1;
    chk("wrap_addr_zero", bus.imem_req_addr, 32'h0);
    step();
    #1;
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    chk("wrap_valid", valid, 1);
    step();
    #1;
    chk("wrap_pc_zero", pc, 32'h0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
